jk_seq_controller: RTL
======================

# jk_seq_controller

Sequencing controller for the team's 2-bit JK-flip-flop state machine. It replaces the ripple/slow-clock scheme with a single-clock design: a programmable tick generator, a run/single-step control FSM, and the JK next-state logic. Every state change happens on the system clock, qualified by a one-cycle tick enable. It sits between board-level controls (run switch, step button, `x` input) and the display logic that consumes `Q`, `Qb`, `Z1` and `Z2`.

## Interface
- `DIV_W`, 26: width of the divider value and tick counter.
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `run`  in  1  level; while high, the FSM advances on every tick.
- `step_req`  in  1  level request for exactly one advance.
- `x`  in  1  FSM input; sampled only on tick cycles.
- `div_val`  in  DIV_W  tick period in clocks; latched when leaving IDLE.
- `Q`  out  2  JK state register.
- `Qb`  out  2  always equals `~Q`.
- `Z1`  out  1  `Q[1] & Q[0]`.
- `Z2`  out  1  `~Q[1] & ~Q[0]`.
- `tick`  out  1  one-cycle advance enable; visible for debug.
- `busy`  out  1  high in RUN or STEP.
- `step_ack`  out  1  one-cycle pulse after a step completes.

## Operation
- **Reset values (async):** `Q`=00, `Qb`=11, `Z1`=0, `Z2`=1, `tick`=0, `busy`=0, `step_ack`=0, control FSM = IDLE, counter = 0, latched divider = 1.
- **JK equations:**
  - `J0 = K0 = ~x & Q[1]`, so `Q[0]` toggles when `x`=0 and `Q[1]`=1.
  - `J1 = ~x`, `K1 = 1`, so `Q[1]` next = `~x & ~Q[1]`.
- **With x=0, the sequence is** 00→10→01→11→00.
- **With x=1:** `Q[1]` next = 0 and `Q[0]` holds.
- **Control FSM states:** IDLE, RUN, STEP, ACK.
  - IDLE: `run`=1 → RUN. Otherwise `step_req`=1 → STEP. Leaving IDLE latches `div_val` (value 0 is latched as 1) and clears the counter.
  - RUN: on `tick`, apply the JK update. `run`=0 → IDLE; counter is cleared and `Q` holds. `step_req` is ignored.
  - STEP: on the first `tick`, apply one JK update, then → ACK. `run` is ignored while in STEP.
  - ACK: `step_ack`=1 for this one cycle. → IDLE if `step_req`=0; otherwise stay in a wait substate with `step_ack`=0 until `step_req` falls, then → IDLE. One request level produces one step.
- **Tick generator:** the counter runs only in RUN/STEP. It counts 0..D-1 (D = latched divider) and `tick`=1 in the cycle where counter = D-1, then wraps to 0. With D=1, `tick` is high every cycle.
- **Simultaneous events:**
  - `run` and `step_req` both high in IDLE: `run` wins, no ack is produced.
  - `div_val` changing mid-run has no effect until the next exit from IDLE.
- **Reset mid-operation:** an immediate return to the reset values, with no pending ack.

## Timing
- **Registered outputs:** `Q` and `Qb` change on the clock edge that ends a `tick` cycle, so the new value is visible the following cycle.
- **Combinational outputs:** `Z1`, `Z2` and `busy` are combinational from registers; `tick` and `step_ack` are registered.
- **`x` sampling:** `x` is sampled in the `tick` cycle only. `x` is treated as already synchronous.
- **First tick after leaving IDLE:** occurs D cycles after the transition edge.
- **Step latency:** `step_req` is seen in IDLE at edge 0. STEP runs D cycles. `Q` updates at edge D+1 and `step_ack` is high during cycle D+1.
- **Run stop:** `run` falling stops advances from the next cycle. A tick coinciding with `run`=0 in RUN still applies the update.

## Structure
- **Package `jk_seq_pkg`:**
  - enum `ctl_state_t` (IDLE, RUN, STEP, ACK, ACK_WAIT);
  - localparam `Q_RESET`=2'b00;
  - the `Z1`/`Z2` decode function.
- **Sub-module `tick_gen`:** inputs `clk`, `reset`, `en`, `div`; output `tick`. Counter only.
- **Top level:** the JK next-state logic and control FSM stay in the top module.

## Test plan
- **Reset mid-run:** assert `reset` mid-run with `Q`=11 → asynchronously `Q`=00, `Qb`=11, `Z2`=1, `busy`=0, `step_ack`=0.
- **Free run, x=0:** `div_val`=3, `x`=0, `run`=1 for 13 cycles → ticks at cycles 3, 6, 9, 12. `Q` goes 10, 01, 11, 00; `Z1`=1 only while `Q`=11.
- **Free run, x=1:** `div_val`=0, `x`=1, `run`=1 from `Q`=11 → `tick` every cycle; `Q` goes 01 and then stays 01.
- **Single step:** `div_val`=4 and a `step_req` pulse held 20 cycles from `Q`=00 with `x`=0 → exactly one advance to 10, one `step_ack` at cycle 5, no further change until `step_req` drops and rises again.
- **Run/step priority:** `run` and `step_req` rise together → RUN entered, no `step_ack`. Drop `run` mid-count → `busy`=0 next cycle, `Q` frozen, counter restarts at 0 on the next run.
- **Divider latch:** change `div_val` from 2 to 5 while in RUN → tick period stays 2. Stop and restart `run` → period becomes 5.

Source files
------------

// File: rtl/jk_seq_pkg.sv
// Shared types and helpers for the JK sequencing controller.
package jk_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    STEP     = 3'd2,
    ACK      = 3'd3,
    ACK_WAIT = 3'd4
  } ctl_state_t;

  localparam logic [1:0] Q_RESET = 2'b00;

  // Returns {Z1, Z2} for a given JK state.
  function automatic logic [1:0] z_decode(input logic [1:0] q);
    return {q[1] & q[0], ~q[1] & ~q[0]};
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Programmable tick counter: one registered tick every div clocks while en is high.
module tick_gen #(
  parameter int DIV_W = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_tick;
  logic             w_last;

  assign w_last = (r_cnt == (div - DIV_W'(1)));

  // Dropping en clears both counter and tick so every enable window restarts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (!en) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_last;
      r_cnt  <= w_last ? '0 : r_cnt + DIV_W'(1);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/jk_seq_controller.sv
// Single-clock run/step controller around a 2-bit JK state machine.
//   state    | meaning
//   IDLE     | waiting for run or step_req; latches divider on exit
//   RUN      | free running, JK update on every tick
//   STEP     | waiting for one tick, then one JK update
//   ACK      | step_ack pulse cycle
//   ACK_WAIT | step_req still high after ack, wait for release
module jk_seq_controller
  import jk_seq_pkg::*;
#(
  parameter int DIV_W = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step_req,
  input  logic             x,
  input  logic [DIV_W-1:0] div_val,
  output logic [1:0]       Q,
  output logic [1:0]       Qb,
  output logic             Z1,
  output logic             Z2,
  output logic             tick,
  output logic             busy,
  output logic             step_ack
);

  ctl_state_t       r_state;
  ctl_state_t       w_state_next;
  logic [1:0]       r_q;
  logic [DIV_W-1:0] r_div;
  logic             r_step_ack;

  logic [1:0] w_j;
  logic [1:0] w_k;
  logic [1:0] w_q_jk;
  logic [1:0] w_z;
  logic       w_tick;
  logic       w_busy;
  logic       w_busy_next;
  logic       w_tick_en;
  logic       w_adv;
  logic       w_leave_idle;

  assign w_j    = {~x, ~x & r_q[1]};
  assign w_k    = {1'b1, ~x & r_q[1]};
  assign w_q_jk = (w_j & ~r_q) | (~w_k & r_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_q        <= Q_RESET;
      r_div      <= DIV_W'(1);
      r_step_ack <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_step_ack <= (r_state == STEP) && w_tick;
      if (w_adv)
        r_q <= w_q_jk;
      if (w_leave_idle)
        r_div <= (div_val == '0) ? DIV_W'(1) : div_val;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:     if (run) w_state_next = RUN;
                else if (step_req) w_state_next = STEP;
      RUN:      if (!run) w_state_next = IDLE;
      STEP:     if (w_tick) w_state_next = ACK;
      ACK:      w_state_next = step_req ? ACK_WAIT : IDLE;
      ACK_WAIT: if (!step_req) w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  // The tick counter only runs while staying busy, so leaving RUN/STEP never leaves a stray tick.
  always_comb begin
    w_busy       = (r_state == RUN) || (r_state == STEP);
    w_busy_next  = (w_state_next == RUN) || (w_state_next == STEP);
    w_tick_en    = w_busy & w_busy_next;
    w_adv        = w_busy & w_tick;
    w_leave_idle = (r_state == IDLE) && (w_state_next != IDLE);
  end

  tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (w_tick_en),
    .div   (r_div),
    .tick  (w_tick)
  );

  assign w_z      = z_decode(r_q);
  assign Q        = r_q;
  assign Qb       = ~r_q;
  assign Z1       = w_z[1];
  assign Z2       = w_z[0];
  assign tick     = w_tick;
  assign busy     = w_busy;
  assign step_ack = r_step_ack;

endmodule
